upconv_c2r: RTL

UPCONV_C2R -- requirements
Module: upconv_c2r

---
 rtl/upconv_pkg.sv | 17 +
 rtl/sat.sv | 21 ++
 rtl/sincos_lut_qw.sv | 45 ++++
 rtl/upconv_c2r.sv | 85 ++++++++
 4 files changed

// File: rtl/upconv_pkg.sv
// rtl/upconv_pkg.sv - shared defaults and quarter-wave sine table generator for the real upconverter
package upconv_pkg;
  localparam int dsz_def = 14;
  localparam int psz_def = 12;
  localparam int asz_def = 26;
  localparam int lut_dw = 16;
  localparam int lat = 7;
  localparam string lut_file = "sine_qw_4096.hex";
  localparam real two_pi = 6.283185307179586;

  // Entry k holds round(0x7FFF * sin(2*pi*k / 2^pw)); entry 0 is exactly zero.
  function automatic logic signed [lut_dw-1:0] qw_sine(input int k, input int pw);
    real ang;
    ang = two_pi * $itor(k) / $itor(1 << pw);
    return lut_dw'($rtoi($floor(32767.0 * $sin(ang) + 0.5)));
  endfunction
endpackage

// File: rtl/sat.sv
// rtl/sat.sv - signed saturator from isz bits down to osz bits
module sat #(
  parameter int isz = 15,
  parameter int osz = 14
) (
  input  logic signed [isz-1:0] din,
  output logic signed [osz-1:0] dout
);
  localparam int max_i = (1 << (osz - 1)) - 1;
  localparam logic signed [isz-1:0] max_v = isz'(max_i);
  localparam logic signed [isz-1:0] min_v = isz'(-max_i - 1);

  always_comb begin
    dout = din[osz-1:0];
    if (din > max_v) begin
      dout = max_v[osz-1:0];
    end else if (din < min_v) begin
      dout = min_v[osz-1:0];
    end
  end
endmodule

// File: rtl/sincos_lut_qw.sv
// rtl/sincos_lut_qw.sv - quarter-wave sine lookup with quadrant fold and negate, three register stages
module sincos_lut_qw
  import upconv_pkg::*;
#(
  parameter int psz = psz_def
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [psz-1:0]           phase,
  input  logic                     shift,
  output logic signed [lut_dw-1:0] value
);
  localparam int aw = psz - 2;
  localparam int depth = 1 << aw;

  logic [1:0]               quad;
  logic [aw-1:0]            addr_r;
  logic                     neg_r;
  logic                     neg_rr;
  logic signed [lut_dw-1:0] rom_q;
  logic signed [lut_dw-1:0] rom [depth];

  for (genvar k = 0; k < depth; k++) begin : g_rom
    assign rom[k] = qw_sine(k, psz);
  end

  // Odd quadrants walk the table backwards, upper half-cycle negates.
  assign quad = phase[psz-1 -: 2] + {1'b0, shift};

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r <= '0;
      neg_r  <= 1'b0;
      rom_q  <= '0;
      neg_rr <= 1'b0;
      value  <= '0;
    end else begin
      addr_r <= phase[aw-1:0] ^ {aw{quad[0]}};
      neg_r  <= quad[1];
      rom_q  <= rom[addr_r];
      neg_rr <= neg_r;
      value  <= neg_rr ? -rom_q : rom_q;
    end
  end
endmodule

// File: rtl/upconv_c2r.sv
// rtl/upconv_c2r.sv - complex baseband to real upconverter: NCO, I*cos - Q*sin, round, saturate
module upconv_c2r
  import upconv_pkg::*;
#(
  parameter int dsz = dsz_def,
  parameter int psz = psz_def,
  parameter int asz = asz_def
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic [asz-1:0]        frq,
  input  logic                  phs_clr,
  input  logic signed [dsz-1:0] in_i,
  input  logic signed [dsz-1:0] in_q,
  output logic signed [dsz-1:0] out,
  output logic                  valid
);
  localparam int dly = 4;
  localparam logic signed [dsz+16:0] half = (dsz+17)'(16384);

  logic [asz-1:0]           acc;
  logic [psz-1:0]           ph;
  logic signed [dsz-1:0]    i_d [dly];
  logic signed [dsz-1:0]    q_d [dly];
  logic [lat-1:0]           vld;
  logic signed [lut_dw-1:0] sin_v;
  logic signed [lut_dw-1:0] cos_v;
  logic signed [dsz+15:0]   prod_i;
  logic signed [dsz+15:0]   prod_q;
  logic signed [dsz+16:0]   diff;
  logic signed [dsz:0]      rnd;
  logic signed [dsz-1:0]    sat_v;

  sincos_lut_qw #(.psz(psz)) u_sin (
    .clk(clk), .reset(reset), .phase(ph), .shift(1'b0), .value(sin_v)
  );

  sincos_lut_qw #(.psz(psz)) u_cos (
    .clk(clk), .reset(reset), .phase(ph), .shift(1'b1), .value(cos_v)
  );

  sat #(.isz(dsz + 1), .osz(dsz)) u_sat (
    .din(rnd), .dout(sat_v)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      ph     <= '0;
      vld    <= '0;
      prod_i <= '0;
      prod_q <= '0;
      diff   <= '0;
      rnd    <= '0;
      out    <= '0;
      valid  <= 1'b0;
      for (int k = 0; k < dly; k++) begin
        i_d[k] <= '0;
        q_d[k] <= '0;
      end
    end else begin
      // The sample's phase is the accumulator before this strobe's update.
      if (ena) begin
        acc <= phs_clr ? frq : acc + frq;
      end
      ph     <= (ena && phs_clr) ? '0 : acc[asz-1 -: psz];
      i_d[0] <= in_i;
      q_d[0] <= in_q;
      for (int k = 1; k < dly; k++) begin
        i_d[k] <= i_d[k-1];
        q_d[k] <= q_d[k-1];
      end
      vld    <= {vld[lat-2:0], ena};
      prod_i <= (dsz+16)'(i_d[dly-1]) * (dsz+16)'(cos_v);
      prod_q <= (dsz+16)'(q_d[dly-1]) * (dsz+16)'(sin_v);
      diff   <= (dsz+17)'(prod_i) - (dsz+17)'(prod_q);
      rnd    <= (dsz+1)'((diff + half) >>> 15);
      valid  <= vld[lat-1];
      if (vld[lat-1]) begin
        out <= sat_v;
      end
    end
  end
endmodule
